cfg_reg_arbiter: RTL and testbench

CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

---
 rtl/cfg_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cfg_reg_arbiter.sv | 99 +++++++++
 tb/tb_cfg_reg_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_arb_pkg.sv
// Shared types and field positions for the config register arbiter.
// Packet layout: bit 27 write, 26:24 register address, 23:0 data.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int WR_BIT  = 27;
    localparam int ADDR_HI = 26;
    localparam int ADDR_LO = 24;
    localparam int DATA_HI = 23;

    // Read of reg 0 with the write bit clear: safe to present on any cycle.
    localparam logic [31:0] IDLE_PACKET = 32'h0000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts one past last_grant and wraps.
// Latency: combinational. Backpressure: none; the caller decides when a pick is taken.
// The grant is one-hot and is all-zero when no request is present.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Arbitrates NUM_REQ requesters onto one config register file port.
// Latency: accept -> rsp_valid 2 cycles; reads every 3 cycles, unacked writes every 2.
// Backpressure: one transaction in flight; no new grant until the response is taken.
// Optional macro: CFG_ARB_WRITE_ACK_EN gives writes a response carrying the written data.
module cfg_reg_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_packet,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [WIDTH-9:0]                rsp_data,
    output logic                            rsp_err,
    output logic [WIDTH-1:0]                cfg_packet,
    input  logic [WIDTH-9:0]                cfg_read_data,
    input  logic                            cfg_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DW    = WIDTH - 8;

    state_t             state;
    logic               run_q;
    logic [WIDTH-1:0]   pkt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   last_grant;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               take;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // run_q holds off arbitration until one full edge has passed after reset release.
    assign take       = (state == IDLE) && run_q && (|req_valid);
    assign req_ready  = take ? arb_grant : '0;
    assign rsp_valid  = (state == RESP) ? grant_q : '0;
    // The register file writes whenever bit 27 is set, so only ISSUE may show pkt_q.
    assign cfg_packet = (state == ISSUE) ? pkt_q : WIDTH'(IDLE_PACKET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_q      <= 1'b0;
            pkt_q      <= '0;
            grant_q    <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (take) begin
                        pkt_q      <= req_packet[arb_idx];
                        grant_q    <= arb_grant;
                        last_grant <= arb_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!pkt_q[WR_BIT]) begin
                        rsp_data <= cfg_read_data;
                        rsp_err  <= ~cfg_valid;
                        state    <= RESP;
                    end else begin
`ifdef CFG_ARB_WRITE_ACK_EN
                        rsp_data <= pkt_q[DW-1:0];
                        rsp_err  <= 1'b0;
                        state    <= RESP;
`else
                        state    <= IDLE;
`endif
                    end
                end
                RESP: begin
                    if (|(rsp_ready & grant_q)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed bench for cfg_reg_arbiter with a behavioural 8-entry register file;
// address 7 answers with cfg_valid low and junk data.
module tb_cfg_reg_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_packet;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [23:0]      rsp_data;
    logic             rsp_err;
    logic [31:0]      cfg_packet;
    logic [23:0]      cfg_read_data;
    logic             cfg_valid;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [23:0] regs [8] = '{default: '0};

    always #5 clk = ~clk;

    cfg_reg_arbiter #(
        .WIDTH   (32),
        .NUM_REQ (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_packet    (req_packet),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cfg_packet    (cfg_packet),
        .cfg_read_data (cfg_read_data),
        .cfg_valid     (cfg_valid)
    );

    assign cfg_valid     = (cfg_packet[26:24] != 3'd7);
    assign cfg_read_data = cfg_valid ? regs[cfg_packet[26:24]] : 24'hDEAD00;

    always @(posedge clk) begin
        if (cfg_packet[27]) begin
            regs[cfg_packet[26:24]] <= cfg_packet[23:0];
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] pk(input logic w, input logic [2:0] a, input logic [23:0] d);
        return {4'h0, w, a, d};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 2'b00;
        req_packet[1] = '0;
        req_packet[0] = pk(1'b1, 3'd2, 24'h111111);
        req_valid  = 2'b01;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_cfg_packet", cfg_packet, 32'h0);
        req_valid = 2'b00;
        step;
        step;
        rst_n = 1'b1;
        step;

        // Write reg 3 = ABCDEF, upper nibble must pass through to the register file port
        req_packet[0] = 32'h5BABCDEF;
        req_valid     = 2'b01;
        #1;
        check("wr_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        #1;
        check("wr_issue_pkt", cfg_packet, 32'h5BABCDEF);
        check("wr_issue_ready", 32'(req_ready), 32'h0);
        step;
`ifdef CFG_ARB_WRITE_ACK_EN
        check("wr_ack_valid", 32'(rsp_valid), 32'h1);
        check("wr_ack_data", 32'(rsp_data), 32'hABCDEF);
        step;
`else
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);
`endif
        check("wr_idle_pkt", cfg_packet, 32'h0);
        check("wr_count1", 32'(wr_cnt), 32'h1);

        // Read reg 3 back through requester 1
        req_packet[1] = pk(1'b0, 3'd3, 24'h0);
        req_valid     = 2'b10;
        rsp_ready     = 2'b11;
        #1;
        check("rd3_grant", 32'(req_ready), 32'h2);
        step;
        req_valid = 2'b00;
        check("rd3_issue_pkt", cfg_packet, 32'h03000000);
        check("rd3_issue_rsp", 32'(rsp_valid), 32'h0);
        step;
        check("rd3_rsp_valid", 32'(rsp_valid), 32'h2);
        check("rd3_rsp_data", 32'(rsp_data), 32'hABCDEF);
        check("rd3_rsp_err", 32'(rsp_err), 32'h0);
        step;
        check("rd3_done", 32'(rsp_valid), 32'h0);
        check("wr_count_still1", 32'(wr_cnt), 32'h1);

        // Read of an address the register file does not validate
        req_packet[0] = pk(1'b0, 3'd7, 24'h0);
        req_valid     = 2'b01;
        #1;
        check("err_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b00;
        step;
        check("err_rsp_valid", 32'(rsp_valid), 32'h1);
        check("err_rsp_data", 32'(rsp_data), 32'hDEAD00);
        check("err_rsp_err", 32'(rsp_err), 32'h1);
        step;

        // Both requesters from reset: grants alternate starting at 0
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        req_packet[0] = pk(1'b0, 3'd3, 24'h0);
        req_packet[1] = pk(1'b0, 3'd7, 24'h0);
        req_valid     = 2'b11;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            step;
            check("rr_issue_ready", 32'(req_ready), 32'h0);
            step;
            check("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_rsp_data", 32'(rsp_data), (k % 2 == 0) ? 32'hABCDEF : 32'hDEAD00);
            if (k == 7) req_valid = 2'b00;
            step;
        end

        // Backpressure: only the granted requester's rsp_ready counts
        req_packet[0] = pk(1'b0, 3'd3, 24'h0);
        req_valid     = 2'b01;
        rsp_ready     = 2'b10;
        #1;
        check("bp_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b10;
        step;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_data", 32'(rsp_data), 32'hABCDEF);
            check("bp_no_grant", 32'(req_ready), 32'h0);
            check("bp_idle_pkt", cfg_packet, 32'h0);
            if (i == 4) rsp_ready = 2'b01;
            step;
        end
        check("bp_released", 32'(rsp_valid), 32'h0);
        check("bp_next_grant", 32'(req_ready), 32'h2);
        step;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step;
        check("bp_req1_rsp", 32'(rsp_valid), 32'h2);
        check("bp_req1_err", 32'(rsp_err), 32'h1);
        step;

        // Reset during ISSUE of a write of 123456 to reg 5
        req_packet[0] = 32'h0D123456;
        req_valid     = 2'b01;
        #1;
        check("rst_wr_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b00;
        check("rst_wr_issue", cfg_packet, 32'h0D123456);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pkt", cfg_packet, 32'h0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_mid_rsp_err", 32'(rsp_err), 32'h0);
        step;
        rst_n = 1'b1;
        step;
        check("rst_no_write", 32'(wr_cnt), 32'h1);
        check("rst_no_rsp", 32'(rsp_valid), 32'h0);
        req_packet[0] = pk(1'b0, 3'd5, 24'h0);
        req_packet[1] = pk(1'b0, 3'd7, 24'h0);
        req_valid     = 2'b11;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b00;
        step;
        check("rd5_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd5_rsp_data", 32'(rsp_data), 32'h0);
        check("rd5_rsp_err", 32'(rsp_err), 32'h0);
        step;

        // Write 55 to reg 1, requester keeps asking with a read of reg 1
        req_packet[0] = 32'h09000055;
        req_valid     = 2'b01;
        rsp_ready     = 2'b01;
        #1;
        check("m_grant", 32'(req_ready), 32'h1);
        step;
        req_packet[0] = pk(1'b0, 3'd1, 24'h0);
        #1;
        check("m_issue_pkt", cfg_packet, 32'h09000055);
        check("m_issue_ready", 32'(req_ready), 32'h0);
        step;
`ifdef CFG_ARB_WRITE_ACK_EN
        check("m_ack_valid", 32'(rsp_valid), 32'h1);
        check("m_ack_data", 32'(rsp_data), 32'h55);
        check("m_ack_err", 32'(rsp_err), 32'h0);
        check("m_ack_no_grant", 32'(req_ready), 32'h0);
        step;
`else
        check("m_no_rsp", 32'(rsp_valid), 32'h0);
`endif
        check("m_regrant", 32'(req_ready), 32'h1);
        step;
        req_valid = 2'b00;
        step;
        check("rd1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd1_rsp_data", 32'(rsp_data), 32'h55);
        check("rd1_rsp_err", 32'(rsp_err), 32'h0);
        step;
        check("wr_count2", 32'(wr_cnt), 32'h2);
        check("final_idle_pkt", cfg_packet, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
